// File: rtl/fp_align_unit.sv
// fp_align_unit: single-precision operand alignment ahead of an FP adder.
// Swaps to put the larger exponent first, then right-shifts the smaller mantissa with sticky.
module fp_align_unit #(
  parameter int SHIFT_CLAMP = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        big_sign,
  output logic        small_sign,
  output logic        eff_sub,
  output logic [7:0]  exp_out,
  output logic [23:0] mant_big,
  output logic [26:0] mant_small
);

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    SHIFT,
    DONE
  } st_t;

  st_t         st;
  st_t         st_nx;
  logic [31:0] ra;
  logic [31:0] rb;
  logic [4:0]  cnt;

  logic [7:0]  ea;
  logic [7:0]  eb;
  logic        ha;
  logic        hb;
  logic [8:0]  diff;
  logic [8:0]  mag;
  logic        swap;
  logic [4:0]  cnt_ld;
  logic [23:0] ma;
  logic [23:0] mb;

  // exponent compare and clamped shift count from the captured operands
  always_comb begin
    ha     = |ra[30:23];
    hb     = |rb[30:23];
    ea     = ha ? ra[30:23] : 8'd1;
    eb     = hb ? rb[30:23] : 8'd1;
    ma     = {ha, ra[22:0]};
    mb     = {hb, rb[22:0]};
    diff   = {1'b0, ea} + ~{1'b0, eb} + 9'd1;
    swap   = diff[8];
    mag    = swap ? (~diff + 9'd1) : diff;
    cnt_ld = (mag > 9'(SHIFT_CLAMP)) ? 5'(SHIFT_CLAMP) : mag[4:0];
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nx;
  end

  // next state; SHIFT spends one final cycle seeing cnt==0,
  // which gives a fixed 2+cnt latency from accept
  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:  if (in_valid) st_nx = CMP;
      CMP:   st_nx = SHIFT;
      SHIFT: if (cnt == 5'd0) st_nx = DONE;
      DONE:  if (out_ready) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    in_ready  = (st == IDLE);
    out_valid = (st == DONE);
  end

  // operand capture, swap/load and sticky shift datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra         <= '0;
      rb         <= '0;
      cnt        <= '0;
      big_sign   <= 1'b0;
      small_sign <= 1'b0;
      eff_sub    <= 1'b0;
      exp_out    <= '0;
      mant_big   <= '0;
      mant_small <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (in_valid) begin
            ra <= a;
            rb <= b;
          end
        end
        CMP: begin
          cnt        <= cnt_ld;
          eff_sub    <= ra[31] ^ rb[31];
          big_sign   <= swap ? rb[31] : ra[31];
          small_sign <= swap ? ra[31] : rb[31];
          exp_out    <= swap ? eb : ea;
          mant_big   <= swap ? mb : ma;
          mant_small <= {(swap ? ma : mb), 3'b000};
        end
        SHIFT: begin
          if (cnt != 5'd0) begin
            cnt        <= cnt - 5'd1;
            mant_small <= {1'b0, mant_small[26:2],
                           mant_small[1] | mant_small[0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_unit.sv
// tb_fp_align_unit: directed vectors, queue scoreboard and monitor.
// Checks fields, latency, hold under backpressure, ignored input and reset abort.
module tb_fp_align_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        big_sign;
  logic        small_sign;
  logic        eff_sub;
  logic [7:0]  exp_out;
  logic [23:0] mant_big;
  logic [26:0] mant_small;

  typedef struct {
    logic        bs;
    logic        ss;
    logic        es;
    logic [7:0]  ex;
    logic [23:0] mb;
    logic [26:0] ms;
    int          lat;
    time         t_acc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   seen = 0;
  int   vecs = 0;
  int   errs = 0;

  fp_align_unit #(.SHIFT_CLAMP(26)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .big_sign(big_sign), .small_sign(small_sign),
    .eff_sub(eff_sub), .exp_out(exp_out),
    .mant_big(mant_big), .mant_small(mant_small)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // monitor: first valid cycle pops, later valid cycles check hold
  always @(negedge clk) begin
    if (!rst_n || !out_valid) begin
      seen <= 0;
    end else begin
      if (!seen) begin
        if (q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_out: out_valid with empty queue");
          cur = '{default: '0};
        end else begin
          cur = q.pop_front();
          chk("latency", ($time - 5 - cur.t_acc) / 10, cur.lat);
        end
        seen <= 1;
      end
      chk("big_sign", big_sign, cur.bs);
      chk("small_sign", small_sign, cur.ss);
      chk("eff_sub", eff_sub, cur.es);
      chk("exp_out", exp_out, cur.ex);
      chk("mant_big", mant_big, cur.mb);
      chk("mant_small", mant_small, cur.ms);
      chk("in_ready_busy", in_ready, 1'b0);
    end
  end

  task automatic send(input logic [31:0] av, input logic [31:0] bv,
                      input exp_t e);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vecs++;
      errs++;
      $display("FAIL send_timeout: in_ready 0 want 1");
    end
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    e.t_acc = $time;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      vecs++;
      errs++;
      $display("FAIL drain_timeout: %0d pending want 0", q.size());
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic exp_t mk(input logic bs, input logic ss,
                              input logic es, input logic [7:0] ex,
                              input logic [23:0] mb,
                              input logic [26:0] ms, input int lat);
    exp_t e;
    e.bs = bs; e.ss = ss; e.es = es; e.ex = ex;
    e.mb = mb; e.ms = ms; e.lat = lat; e.t_acc = 0;
    return e;
  endfunction

  initial begin
    int n;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_mant_small", mant_small, 27'h0);
    chk("rst_exp_out", exp_out, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready", in_ready, 1'b1);

    send(32'h3F800000, 32'h3F800000,
         mk(0, 0, 0, 8'h7F, 24'h800000, 27'h4000000, 2));
    drain();
    send(32'h3F000000, 32'hC0000000,
         mk(1, 0, 1, 8'h80, 24'h800000, 27'h1000000, 4));
    drain();
    send(32'h4B800000, 32'h3F800001,
         mk(0, 0, 0, 8'h97, 24'h800000, 27'h0000005, 26));
    drain();
    send(32'h7F000000, 32'h3F800000,
         mk(0, 0, 0, 8'hFE, 24'h800000, 27'h0000001, 28));
    drain();
    send(32'h00400000, 32'h00000001,
         mk(0, 0, 0, 8'h01, 24'h400000, 27'h0000008, 2));
    drain();

    out_ready = 1'b0;
    send(32'h3F000000, 32'hC0000000,
         mk(1, 0, 1, 8'h80, 24'h800000, 27'h1000000, 4));
    a = 32'h12345678;
    b = 32'h87654321;
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_done", out_valid, 1'b1);
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_exit_in_ready", in_ready, 1'b1);
    chk("bp_exit_out_valid", out_valid, 1'b0);
    drain();

    send(32'h7F000000, 32'h3F800000,
         mk(0, 0, 0, 8'hFE, 24'h800000, 27'h0000001, 28));
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    void'(q.pop_back());
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_mant_small", mant_small, 27'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_rel_in_ready", in_ready, 1'b1);
    repeat (30) @(negedge clk);
    chk("abort_no_output", out_valid, 1'b0);
    send(32'h3F800000, 32'h3F800000,
         mk(0, 0, 0, 8'h7F, 24'h800000, 27'h4000000, 2));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
